// File: rtl/spmv_row_feeder.sv
// CSR row feeder: walks a row-pointer stream, emits per-row non-zero counts,
// and pairs each matrix value with its vector element fetched from RAM.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// BASE   | taking row_ptr[0] as the first row base
// NEXT   | taking row_ptr[i+1], computing nnz for row i
// STREAM | forwarding the nnz elements of the current row
// DONE   | job finished, waiting for cfg_start
module spmv_row_feeder #(
  parameter int VEC_AW = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_num_rows,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [31:0]       S_AXIS_ROWPTR_tdata,
  input  logic              S_AXIS_ROWPTR_tvalid,
  output logic              S_AXIS_ROWPTR_tready,
  input  logic [95:0]       S_AXIS_ELEM_tdata,
  input  logic              S_AXIS_ELEM_tvalid,
  output logic              S_AXIS_ELEM_tready,
  output logic              vec_rd_en,
  output logic [VEC_AW-1:0] vec_rd_addr,
  input  logic [63:0]       vec_rd_data,
  output logic [63:0]       M_AXIS_A_tdata,
  output logic              M_AXIS_A_tvalid,
  input  logic              M_AXIS_A_tready,
  output logic [63:0]       M_AXIS_B_tdata,
  output logic              M_AXIS_B_tvalid,
  input  logic              M_AXIS_B_tready,
  output logic [31:0]       M_AXIS_TIMES_tdata,
  output logic              M_AXIS_TIMES_tvalid,
  input  logic              M_AXIS_TIMES_tready
);

  typedef enum logic [2:0] {S_IDLE, S_BASE, S_NEXT, S_STREAM, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  rows_left_q, rows_left_d;
  logic [31:0]  prev_ptr_q, prev_ptr_d;
  logic [31:0]  remaining_q, remaining_d;
  logic [31:0]  times_q, times_d;
  logic         times_vld_q, times_vld_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         rd_pend_q, rd_pend_d;
  logic [63:0]  rd_val_q, rd_val_d;
  logic [127:0] pbuf_q [2];
  logic [127:0] pbuf_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         sent_a_q, sent_a_d;
  logic         sent_b_q, sent_b_d;

  logic         rp_hs, el_hs, a_hs, b_hs, t_hs, pop, col_oob;
  logic [2:0]   slots_used;
  logic [31:0]  nnz;

  // Handshakes, stream outputs and buffer occupancy seen by the element port.
  always_comb begin
    busy                 = (state_q == S_BASE) || (state_q == S_NEXT) || (state_q == S_STREAM);
    done                 = done_q;
    err                  = err_q;
    S_AXIS_ROWPTR_tready = ((state_q == S_BASE) || (state_q == S_NEXT)) && !times_vld_q;
    M_AXIS_A_tvalid      = (cnt_q != 2'd0) && !sent_a_q;
    M_AXIS_B_tvalid      = (cnt_q != 2'd0) && !sent_b_q;
    M_AXIS_A_tdata       = pbuf_q[rd_ptr_q][127:64];
    M_AXIS_B_tdata       = pbuf_q[rd_ptr_q][63:0];
    M_AXIS_TIMES_tvalid  = times_vld_q;
    M_AXIS_TIMES_tdata   = times_q;
    a_hs                 = M_AXIS_A_tvalid && M_AXIS_A_tready;
    b_hs                 = M_AXIS_B_tvalid && M_AXIS_B_tready;
    t_hs                 = M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready;
    rp_hs                = S_AXIS_ROWPTR_tvalid && S_AXIS_ROWPTR_tready;
    pop                  = (cnt_q != 2'd0) && (sent_a_q || a_hs) && (sent_b_q || b_hs);
    // A pair leaving this cycle frees its slot for the element accepted now.
    slots_used           = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    S_AXIS_ELEM_tready   = (state_q == S_STREAM) && (remaining_q != 32'd0) && (slots_used < 3'd2);
    el_hs                = S_AXIS_ELEM_tvalid && S_AXIS_ELEM_tready;
    vec_rd_en            = el_hs;
    vec_rd_addr          = S_AXIS_ELEM_tdata[64 +: VEC_AW];
    col_oob              = (S_AXIS_ELEM_tdata[95:64] >> VEC_AW) != 32'd0;
  end

  // Next-state logic for the row walker, TIMES register and pair buffer.
  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    prev_ptr_d  = prev_ptr_q;
    remaining_d = remaining_q;
    times_d     = times_q;
    times_vld_d = times_vld_q;
    done_d      = done_q;
    err_d       = err_q;
    rd_pend_d   = el_hs;
    rd_val_d    = el_hs ? S_AXIS_ELEM_tdata[63:0] : rd_val_q;
    pbuf_d      = pbuf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sent_a_d    = sent_a_q;
    sent_b_d    = sent_b_q;
    nnz         = 32'd0;

    if (t_hs) times_vld_d = 1'b0;
    if (el_hs && col_oob) err_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          err_d       = 1'b0;
          done_d      = 1'b0;
          rows_left_d = cfg_num_rows;
          if (cfg_num_rows == 32'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_BASE;
          end
        end
      end
      S_BASE: begin
        if (rp_hs) begin
          prev_ptr_d = S_AXIS_ROWPTR_tdata;
          state_d    = S_NEXT;
        end
      end
      S_NEXT: begin
        if (rp_hs) begin
          // A decreasing pointer is corrupt input: flag it and skip the row.
          if (S_AXIS_ROWPTR_tdata < prev_ptr_q) err_d = 1'b1;
          else nnz = S_AXIS_ROWPTR_tdata - prev_ptr_q;
          prev_ptr_d  = S_AXIS_ROWPTR_tdata;
          times_d     = nnz;
          times_vld_d = 1'b1;
          remaining_d = nnz;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (el_hs) remaining_d = remaining_q - 32'd1;
        if ((remaining_q == 32'd0) && (!times_vld_q || t_hs)) begin
          if (rows_left_q != 32'd1) begin
            rows_left_d = rows_left_q - 32'd1;
            state_d     = S_NEXT;
          end else if ((cnt_q == 2'd0) && !rd_pend_q) begin
            // The last row finishes only once all of its pairs have drained.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_pend_q) begin
      pbuf_d[wr_ptr_q] = {rd_val_q, vec_rd_data};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      sent_a_d = 1'b0;
      sent_b_d = 1'b0;
    end else begin
      sent_a_d = sent_a_q || a_hs;
      sent_b_d = sent_b_q || b_hs;
    end
    cnt_d = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  end

  // State register; reset discards any in-flight read and buffered pairs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rows_left_q <= '0;
      prev_ptr_q  <= '0;
      remaining_q <= '0;
      times_q     <= '0;
      times_vld_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_val_q    <= '0;
      pbuf_q[0]   <= '0;
      pbuf_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      sent_a_q    <= 1'b0;
      sent_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      prev_ptr_q  <= prev_ptr_d;
      remaining_q <= remaining_d;
      times_q     <= times_d;
      times_vld_q <= times_vld_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_pend_q   <= rd_pend_d;
      rd_val_q    <= rd_val_d;
      pbuf_q      <= pbuf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      sent_a_q    <= sent_a_d;
      sent_b_q    <= sent_b_d;
    end
  end

endmodule

// File: tb/tb_spmv_row_feeder.sv
// Bench for spmv_row_feeder: stream sources/sinks and a vector RAM model run
// off the falling edge; each scenario compares captured streams to a job model.
module tb_spmv_row_feeder;
  localparam int VEC_AW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cfg_start = 1'b0;
  logic [31:0] cfg_num_rows = '0;
  logic busy, done, err;
  logic [31:0] S_AXIS_ROWPTR_tdata = '0;
  logic S_AXIS_ROWPTR_tvalid = 1'b0, S_AXIS_ROWPTR_tready;
  logic [95:0] S_AXIS_ELEM_tdata = '0;
  logic S_AXIS_ELEM_tvalid = 1'b0, S_AXIS_ELEM_tready;
  logic vec_rd_en;
  logic [VEC_AW-1:0] vec_rd_addr;
  logic [63:0] vec_rd_data = '0;
  logic [63:0] M_AXIS_A_tdata, M_AXIS_B_tdata;
  logic M_AXIS_A_tvalid, M_AXIS_B_tvalid;
  logic M_AXIS_A_tready = 1'b0, M_AXIS_B_tready = 1'b0, M_AXIS_TIMES_tready = 1'b0;
  logic [31:0] M_AXIS_TIMES_tdata;
  logic M_AXIS_TIMES_tvalid;

  spmv_row_feeder #(.VEC_AW(VEC_AW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_num_rows(cfg_num_rows),
    .busy(busy), .done(done), .err(err),
    .S_AXIS_ROWPTR_tdata(S_AXIS_ROWPTR_tdata), .S_AXIS_ROWPTR_tvalid(S_AXIS_ROWPTR_tvalid),
    .S_AXIS_ROWPTR_tready(S_AXIS_ROWPTR_tready),
    .S_AXIS_ELEM_tdata(S_AXIS_ELEM_tdata), .S_AXIS_ELEM_tvalid(S_AXIS_ELEM_tvalid),
    .S_AXIS_ELEM_tready(S_AXIS_ELEM_tready),
    .vec_rd_en(vec_rd_en), .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
    .M_AXIS_A_tdata(M_AXIS_A_tdata), .M_AXIS_A_tvalid(M_AXIS_A_tvalid), .M_AXIS_A_tready(M_AXIS_A_tready),
    .M_AXIS_B_tdata(M_AXIS_B_tdata), .M_AXIS_B_tvalid(M_AXIS_B_tvalid), .M_AXIS_B_tready(M_AXIS_B_tready),
    .M_AXIS_TIMES_tdata(M_AXIS_TIMES_tdata), .M_AXIS_TIMES_tvalid(M_AXIS_TIMES_tvalid),
    .M_AXIS_TIMES_tready(M_AXIS_TIMES_tready)
  );

  initial forever #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0;
  // ready modes: 0 high, 1 toggling, 2 random, 3 low
  int a_mode = 0, b_mode = 0, t_mode = 0, el_gap = 0;
  logic [31:0] job_ptr[$], rp_q[$];
  logic [95:0] job_el[$], el_q[$];
  int rp_idx = 0, el_idx = 0;
  logic rp_hs = 1'b0, el_hs = 1'b0, a_tog = 1'b0;
  logic rd_pend = 1'b0;
  logic [VEC_AW-1:0] rd_pend_addr = '0, last_rd_addr = '0;
  logic [63:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  logic [31:0] got_t[$], exp_t[$];
  logic exp_err;
  int el_cyc[$], a_cyc[$];
  int el_acc = 0, max_out = 0, hold_viol = 0, el_stalls = 0;
  logic a_stall = 1'b0, b_stall = 1'b0, t_stall = 1'b0;
  logic [63:0] a_hold, b_hold;
  logic [31:0] t_hold;

  function automatic logic [63:0] vec_val(input int unsigned a);
    return $realtobits(real'(a) + 0.5);
  endfunction

  function automatic logic pick(input int mode, input logic tog);
    case (mode)
      0: return 1'b1;
      1: return tog;
      2: return 1'($urandom_range(1, 0));
      default: return 1'b0;
    endcase
  endfunction

  // Sources, sinks and the one-cycle vector RAM, all paced by the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      vec_rd_data = rd_pend ? vec_val(int'(rd_pend_addr)) : 64'h0BAD_0BAD_0BAD_0BAD;
      rd_pend = 1'b0;
      if (rp_hs) rp_idx++;
      if (el_hs) el_idx++;
      a_tog = ~a_tog;
      M_AXIS_A_tready = pick(a_mode, a_tog);
      M_AXIS_B_tready = pick(b_mode, a_tog);
      M_AXIS_TIMES_tready = pick(t_mode, ~a_tog);
      S_AXIS_ROWPTR_tvalid = rp_idx < rp_q.size();
      S_AXIS_ROWPTR_tdata = S_AXIS_ROWPTR_tvalid ? rp_q[rp_idx] : '0;
      if (!(S_AXIS_ELEM_tvalid && !el_hs)) begin
        if (el_idx < el_q.size() && $urandom_range(99, 0) >= el_gap) begin
          S_AXIS_ELEM_tvalid = 1'b1;
          S_AXIS_ELEM_tdata = el_q[el_idx];
        end else begin
          S_AXIS_ELEM_tvalid = 1'b0;
          S_AXIS_ELEM_tdata = '0;
        end
      end
      #1;
      if (!rstn) begin
        rp_hs = 1'b0; el_hs = 1'b0;
        a_stall = 1'b0; b_stall = 1'b0; t_stall = 1'b0;
      end else begin
        rp_hs = S_AXIS_ROWPTR_tvalid && S_AXIS_ROWPTR_tready;
        el_hs = S_AXIS_ELEM_tvalid && S_AXIS_ELEM_tready;
        if (S_AXIS_ELEM_tvalid && !S_AXIS_ELEM_tready) el_stalls++;
        if (el_hs) begin el_acc++; el_cyc.push_back(cyc); end
        if (vec_rd_en) begin rd_pend = 1'b1; rd_pend_addr = vec_rd_addr; last_rd_addr = vec_rd_addr; end
        if (a_stall && (!M_AXIS_A_tvalid || M_AXIS_A_tdata !== a_hold)) hold_viol++;
        if (b_stall && (!M_AXIS_B_tvalid || M_AXIS_B_tdata !== b_hold)) hold_viol++;
        if (t_stall && (!M_AXIS_TIMES_tvalid || M_AXIS_TIMES_tdata !== t_hold)) hold_viol++;
        a_stall = M_AXIS_A_tvalid && !M_AXIS_A_tready; a_hold = M_AXIS_A_tdata;
        b_stall = M_AXIS_B_tvalid && !M_AXIS_B_tready; b_hold = M_AXIS_B_tdata;
        t_stall = M_AXIS_TIMES_tvalid && !M_AXIS_TIMES_tready; t_hold = M_AXIS_TIMES_tdata;
        if (M_AXIS_A_tvalid && M_AXIS_A_tready) begin got_a.push_back(M_AXIS_A_tdata); a_cyc.push_back(cyc); end
        if (M_AXIS_B_tvalid && M_AXIS_B_tready) got_b.push_back(M_AXIS_B_tdata);
        if (M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready) got_t.push_back(M_AXIS_TIMES_tdata);
        if (el_acc - ((got_a.size() < got_b.size()) ? got_a.size() : got_b.size()) > max_out)
          max_out = el_acc - ((got_a.size() < got_b.size()) ? got_a.size() : got_b.size());
      end
    end
  end

  // Job model: row i holds ptr[i+1]-ptr[i] elements unless the pointer falls.
  task automatic model_job(input int rows);
    int k;
    longint n;
    logic [31:0] col;
    exp_t.delete(); exp_a.delete(); exp_b.delete();
    exp_err = 1'b0; k = 0;
    for (int r = 0; r < rows; r++) begin
      if (job_ptr[r+1] < job_ptr[r]) begin exp_err = 1'b1; n = 0; end
      else n = longint'(job_ptr[r+1]) - longint'(job_ptr[r]);
      exp_t.push_back(32'(n));
      for (longint i = 0; i < n; i++) begin
        col = job_el[k][95:64];
        exp_a.push_back(job_el[k][63:0]);
        exp_b.push_back(vec_val(col % (32'd1 << VEC_AW)));
        if (col >= (32'd1 << VEC_AW)) exp_err = 1'b1;
        k++;
      end
    end
  endtask

  function automatic int pairs_bad();
    int bad;
    bad = 0;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) return 1000;
    for (int i = 0; i < exp_a.size(); i++)
      if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) bad++;
    return bad;
  endfunction

  function automatic int times_bad();
    int bad;
    bad = 0;
    if (got_t.size() != exp_t.size()) return 1000;
    for (int i = 0; i < exp_t.size(); i++)
      if (got_t[i] !== exp_t[i]) bad++;
    return bad;
  endfunction

  task automatic load_job(input int rows);
    @(negedge clk); #2;
    rp_q = job_ptr; el_q = job_el;
    rp_idx = 0; el_idx = 0; rp_hs = 1'b0; el_hs = 1'b0;
    got_a.delete(); got_b.delete(); got_t.delete(); el_cyc.delete(); a_cyc.delete();
    el_acc = 0; max_out = 0; hold_viol = 0; el_stalls = 0;
    model_job(rows);
  endtask

  task automatic start_pulse(input int rows);
    @(negedge clk); #2;
    cfg_num_rows = rows; cfg_start = 1'b1;
    @(negedge clk); #2;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); #2; n++; end
    repeat (4) @(negedge clk);
    #2;
    total++;
    if (done !== 1'b1) $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, n);
    else passed++;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, err, M_AXIS_A_tvalid, M_AXIS_B_tvalid, M_AXIS_TIMES_tvalid} !== 6'b0)
      $display("FAIL reset_outputs: busy/done/err/A/B/T valids=%b, required 000000",
               {busy, done, err, M_AXIS_A_tvalid, M_AXIS_B_tvalid, M_AXIS_TIMES_tvalid});
    else passed++;
    total++;
    if ({S_AXIS_ROWPTR_tready, S_AXIS_ELEM_tready, vec_rd_en} !== 3'b0)
      $display("FAIL reset_readies: rowptr/elem tready, rd_en=%b, required 000",
               {S_AXIS_ROWPTR_tready, S_AXIS_ELEM_tready, vec_rd_en});
    else passed++;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if ({busy, done, S_AXIS_ROWPTR_tready} !== 3'b0)
      $display("FAIL reset_idle: busy/done/rowptr_ready=%b, required 000", {busy, done, S_AXIS_ROWPTR_tready});
    else passed++;
  endtask

  task automatic test_normal();
    a_mode = 0; b_mode = 0; t_mode = 0; el_gap = 0;
    job_ptr = '{32'd0, 32'd2, 32'd3};
    job_el = '{{32'd1, 32'($urandom), 32'($urandom)}, {32'd4, 32'($urandom), 32'($urandom)},
               {32'd0, 32'($urandom), 32'($urandom)}};
    load_job(2);
    start_pulse(2);
    wait_done("normal", 200);
    total++;
    if (times_bad() !== 0 || got_t.size() != 2 || got_t[0] !== 32'd2 || got_t[1] !== 32'd1)
      $display("FAIL normal_times: %0d TIMES received, mismatches=%0d, required 2,1", got_t.size(), times_bad());
    else passed++;
    total++;
    if (pairs_bad() !== 0 || got_b.size() != 3 || got_b[1] !== $realtobits(4.5))
      $display("FAIL normal_pairs: %0d pairs received, mismatches=%0d, required 3 exact", got_a.size(), pairs_bad());
    else passed++;
    total++;
    if (err !== 1'b0) $display("FAIL normal_err: err=%b, required 0", err); else passed++;
  endtask

  task automatic test_empty_row();
    job_ptr = '{32'd5, 32'd5, 32'd7, 32'd7};
    job_el = '{{32'd9, 32'($urandom), 32'($urandom)}, {32'd12, 32'($urandom), 32'($urandom)}};
    load_job(3);
    start_pulse(3);
    wait_done("empty", 200);
    total++;
    if (times_bad() !== 0 || got_t.size() != 3)
      $display("FAIL empty_times: %0d TIMES received, mismatches=%0d, required 0,2,0", got_t.size(), times_bad());
    else passed++;
    total++;
    if (pairs_bad() !== 0) $display("FAIL empty_pairs: %0d pairs received, required 2", got_a.size());
    else passed++;
  endtask

  task automatic test_zero_rows();
    job_ptr = '{32'h77};
    job_el.delete();
    load_job(0);
    start_pulse(0);
    wait_done("zero_rows", 20);
    total++;
    if (rp_idx !== 0 || busy !== 1'b0)
      $display("FAIL zero_rows_consume: rowptrs taken=%0d busy=%b, required 0 and 0", rp_idx, busy);
    else passed++;
  endtask

  task automatic test_errors();
    job_ptr = '{32'd4, 32'd2, 32'd3};
    job_el = '{{32'h0001_0003, 32'($urandom), 32'($urandom)}};
    load_job(2);
    start_pulse(2);
    wait_done("errors", 200);
    total++;
    if (err !== 1'b1) $display("FAIL errors_err: err=%b, required 1", err); else passed++;
    total++;
    if (times_bad() !== 0 || got_t.size() != 2 || got_t[0] !== 32'd0)
      $display("FAIL errors_times: %0d TIMES received, mismatches=%0d, required 0,1", got_t.size(), times_bad());
    else passed++;
    total++;
    if (last_rd_addr !== 16'h0003) $display("FAIL errors_addr: rd_addr=%h, required 0003", last_rd_addr);
    else passed++;
    total++;
    if (pairs_bad() !== 0) $display("FAIL errors_pair: %0d pairs, mismatches=%0d", got_a.size(), pairs_bad());
    else passed++;
    start_pulse(0);
    total++;
    if (err !== 1'b0) $display("FAIL errors_clear: err=%b after restart, required 0", err); else passed++;
  endtask

  task automatic test_start_while_busy();
    el_gap = 60;
    job_ptr = '{32'd0, 32'd3, 32'd4};
    job_el = '{{32'd7, 32'($urandom), 32'($urandom)}, {32'd8, 32'($urandom), 32'($urandom)},
               {32'd2, 32'($urandom), 32'($urandom)}, {32'd3, 32'($urandom), 32'($urandom)}};
    load_job(2);
    start_pulse(2);
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_flag: busy=%b during job, required 1", busy); else passed++;
    start_pulse(7);
    wait_done("busy_start", 400);
    total++;
    if (times_bad() !== 0 || pairs_bad() !== 0)
      $display("FAIL busy_ignore: TIMES mismatches=%0d pair mismatches=%0d, required 0", times_bad(), pairs_bad());
    else passed++;
    el_gap = 0;
  endtask

  task automatic test_backpressure();
    a_mode = 1; b_mode = 2; t_mode = 2; el_gap = 0;
    job_ptr = '{32'd0, 32'd100};
    job_el.delete();
    for (int i = 0; i < 100; i++) job_el.push_back({32'($urandom_range(65535, 0)), 32'($urandom), 32'($urandom)});
    load_job(1);
    start_pulse(1);
    wait_done("backpressure", 2000);
    total++;
    if (pairs_bad() !== 0) $display("FAIL bp_pairs: %0d pairs, mismatches=%0d, required 100 exact", got_a.size(), pairs_bad());
    else passed++;
    total++;
    if (hold_viol !== 0) $display("FAIL bp_hold: %0d valid/data changes while stalled, required 0", hold_viol);
    else passed++;
    total++;
    if (max_out > 2 || el_stalls == 0)
      $display("FAIL bp_stall: max outstanding=%0d elem stalls=%0d, required <=2 and >0", max_out, el_stalls);
    else passed++;
    a_mode = 0; b_mode = 0; t_mode = 0;
  endtask

  task automatic test_throughput();
    int lat, span_a, span_e;
    job_ptr = '{32'd0, 32'd64};
    job_el.delete();
    for (int i = 0; i < 64; i++) job_el.push_back({32'(i * 3), 32'($urandom), 32'($urandom)});
    load_job(1);
    start_pulse(1);
    wait_done("throughput", 400);
    lat = (a_cyc.size() == 64 && el_cyc.size() == 64) ? a_cyc[0] - el_cyc[0] : -1;
    span_a = (a_cyc.size() == 64) ? a_cyc[63] - a_cyc[0] : -1;
    span_e = (el_cyc.size() == 64) ? el_cyc[63] - el_cyc[0] : -1;
    total++;
    if (pairs_bad() !== 0) $display("FAIL tput_pairs: %0d pairs, mismatches=%0d", got_a.size(), pairs_bad());
    else passed++;
    total++;
    if (lat !== 2) $display("FAIL tput_latency: %0d cycles elem->A, required 2", lat); else passed++;
    total++;
    if (span_a !== 63 || span_e !== 63)
      $display("FAIL tput_rate: A span=%0d elem span=%0d, required 63 and 63", span_a, span_e);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    a_mode = 3; b_mode = 3; t_mode = 0;
    job_ptr = '{32'd0, 32'd0, 32'd3};
    job_el = '{{32'd1, 32'($urandom), 32'($urandom)}, {32'd2, 32'($urandom), 32'($urandom)},
               {32'd3, 32'($urandom), 32'($urandom)}};
    load_job(2);
    start_pulse(2);
    n = 0;
    while (el_acc < 1 && n < 200) begin @(negedge clk); #2; n++; end
    repeat (3) @(negedge clk);
    #3;
    total++;
    if (M_AXIS_A_tvalid !== 1'b1) $display("FAIL rstmid_pre: A tvalid=%b before reset, required 1", M_AXIS_A_tvalid);
    else passed++;
    rstn = 1'b0;
    #1;
    total++;
    if ({M_AXIS_A_tvalid, M_AXIS_B_tvalid, M_AXIS_TIMES_tvalid, busy, done, err} !== 6'b0)
      $display("FAIL rstmid_valids: A/B/T valid,busy,done,err=%b, required 000000",
               {M_AXIS_A_tvalid, M_AXIS_B_tvalid, M_AXIS_TIMES_tvalid, busy, done, err});
    else passed++;
    total++;
    if ({S_AXIS_ROWPTR_tready, S_AXIS_ELEM_tready, vec_rd_en} !== 3'b0)
      $display("FAIL rstmid_readies: rowptr/elem tready, rd_en=%b, required 000",
               {S_AXIS_ROWPTR_tready, S_AXIS_ELEM_tready, vec_rd_en});
    else passed++;
    repeat (2) @(negedge clk);
    #5;
    rp_q.delete(); el_q.delete(); rp_idx = 0; el_idx = 0; rd_pend = 1'b0;
    S_AXIS_ELEM_tvalid = 1'b0; S_AXIS_ROWPTR_tvalid = 1'b0;
    a_mode = 0; b_mode = 0;
    rstn = 1'b1;
    job_ptr = '{32'd10, 32'd13};
    job_el = '{{32'd20, 32'($urandom), 32'($urandom)}, {32'd21, 32'($urandom), 32'($urandom)},
               {32'd22, 32'($urandom), 32'($urandom)}};
    load_job(1);
    start_pulse(1);
    wait_done("rstmid_job", 200);
    total++;
    if (times_bad() !== 0 || pairs_bad() !== 0 || err !== 1'b0)
      $display("FAIL rstmid_clean: TIMES mism=%0d pair mism=%0d err=%b, required 0,0,0", times_bad(), pairs_bad(), err);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] p, nx, col;
    int rows, tot;
    for (int it = 0; it < 6; it++) begin
      rows = $urandom_range(5, 1);
      a_mode = $urandom_range(2, 0); b_mode = $urandom_range(2, 0); t_mode = $urandom_range(2, 0);
      el_gap = $urandom_range(50, 0);
      job_ptr.delete(); job_el.delete();
      p = $urandom_range(1000, 0); tot = 0;
      job_ptr.push_back(p);
      for (int r = 0; r < rows; r++) begin
        if ($urandom_range(9, 0) == 0) nx = p - $urandom_range(3, 1);
        else nx = p + $urandom_range(6, 0);
        if (nx >= p) tot += int'(nx - p);
        job_ptr.push_back(nx);
        p = nx;
      end
      for (int k = 0; k < tot; k++) begin
        col = ($urandom_range(7, 0) == 0) ? 32'h0001_0000 + $urandom_range(255, 0) : $urandom_range(65535, 0);
        job_el.push_back({col, 32'($urandom), 32'($urandom)});
      end
      load_job(rows);
      start_pulse(rows);
      wait_done("random", 2000);
      total++;
      if (times_bad() !== 0 || pairs_bad() !== 0)
        $display("FAIL random_streams it%0d: TIMES mism=%0d pair mism=%0d", it, times_bad(), pairs_bad());
      else passed++;
      total++;
      if (err !== exp_err || hold_viol !== 0)
        $display("FAIL random_err it%0d: err=%b hold_viol=%0d, required err=%b hold_viol=0", it, err, hold_viol, exp_err);
      else passed++;
    end
    a_mode = 0; b_mode = 0; t_mode = 0; el_gap = 0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_empty_row();
    test_zero_rows();
    test_errors();
    test_start_while_busy();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spmv_row_feeder.md
SPMV_ROW_FEEDER -- requirements
Module: spmv_row_feeder

Interface
REQ-001 Parameter VEC_AW, default 16: vector RAM address width; valid column indices are 0..2^VEC_AW-1.
REQ-002 clk  in  1  single clock; all logic is on its rising edge.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 cfg_start  in  1  one-cycle pulse that starts a job; honoured only in IDLE or DONE.
REQ-005 cfg_num_rows  in  32  number of rows in the job, sampled on cfg_start.
REQ-006 busy / done / err  out  1 each  job running / job finished (sticky until next cfg_start) / sticky error.
REQ-007 S_AXIS_ROWPTR_tdata/tvalid/tready  in/in/out  32/1/1  CSR row-pointer stream; cfg_num_rows+1 words per job.
REQ-008 S_AXIS_ELEM_tdata/tvalid/tready  in/in/out  96/1/1  non-zero stream; [63:0] matrix value (double), [95:64] column index.
REQ-009 vec_rd_en / vec_rd_addr / vec_rd_data  out/out/in  1/VEC_AW/64  vector RAM read port; data valid exactly 1 cycle after vec_rd_en.
REQ-010 M_AXIS_A_tdata/tvalid/tready  out/out/in  64/1/1  matrix-value stream to the dot-product engine.
REQ-011 M_AXIS_B_tdata/tvalid/tready  out/out/in  64/1/1  vector-element stream to the dot-product engine.
REQ-012 M_AXIS_TIMES_tdata/tvalid/tready  out/out/in  32/1/1  per-row non-zero count.

Function
REQ-013 States: IDLE, BASE (take row_ptr[0]), NEXT (take row_ptr[i+1]), STREAM (forward row elements), DONE.
REQ-014 IDLE/DONE -> BASE on cfg_start; cfg_start with cfg_num_rows=0 goes directly to DONE and consumes no row pointer.
REQ-015 BASE: accept one ROWPTR beat into prev_ptr, -> NEXT.
REQ-016 NEXT: accept one ROWPTR beat cur; nnz = cur - prev_ptr (32-bit); prev_ptr <= cur; TIMES output loaded with nnz; -> STREAM.
REQ-017 If cur < prev_ptr: err set, nnz forced to 0.
REQ-018 STREAM: accept exactly nnz ELEM beats; when all accepted and TIMES beat handed off, -> NEXT, or -> DONE after cfg_num_rows rows.
REQ-019 Rows with nnz=0 emit TIMES=0 and no A/B beats.
REQ-020 S_AXIS_ROWPTR_tready is high only in BASE/NEXT with the TIMES register empty; S_AXIS_ELEM_tready is high only in STREAM with remaining>0 and pair-buffer room.
REQ-021 Each accepted element issues vec_rd_en with vec_rd_addr = col[VEC_AW-1:0] in the same cycle; col >= 2^VEC_AW sets err and the truncated address is still used.
REQ-022 One cycle later {val, vec_rd_data} is written as a pair into a 2-entry pair buffer; room check counts stored plus in-flight pairs (<2).
REQ-023 Buffer head drives M_AXIS_A and M_AXIS_B; each channel's tvalid stays high until its own handshake; the head pops only after both channels have handshaken (per-channel sent flags).
REQ-024 Pair order equals ELEM accept order; no pair is dropped, duplicated or reordered under any backpressure.
REQ-025 Sustained throughput is 1 pair/cycle with A and B ready held high; A/B latency is 2 cycles from ELEM handshake to tvalid.
REQ-026 TIMES for row i is presented no later than row i's first A/B pair and never after row i+1's first pair.
REQ-027 busy = state is BASE, NEXT or STREAM; done is set on entry to DONE; done and err clear on an accepted cfg_start.
REQ-028 cfg_start while busy is ignored.
REQ-029 AXIS outputs hold tdata stable while tvalid is high and not ready.

Reset
REQ-030 On rstn low, asynchronously: state IDLE; all tvalid, tready, vec_rd_en, busy, done and err are 0; pair buffer and counters are cleared; in-flight reads are discarded.
REQ-031 Reset deassertion mid-job resumes in IDLE; no partial row output occurs after reset.

Verification
REQ-032 Normal job: rows=2, ptr {0,2,3}, cols {1,4,0}, vec[k]=k+0.5 -> TIMES 2,1; pairs (v0,1.5),(v1,4.5),(v2,0.5); done=1, err=0.
REQ-033 Empty row: rows=3, ptr {5,5,7,7} -> TIMES 0,2,0; exactly 2 pairs; done=1.
REQ-034 Backpressure: A ready toggled at 50%, B ready random, 100-element row -> 100 correct ordered pairs; no tvalid drop before handshake; ELEM stalls when buffer full.
REQ-035 Errors: ptr {4,2}, then col 0x0001_0003 with VEC_AW=16 -> err=1, TIMES=0 for the bad row, read address 0x0003.
REQ-036 Reset mid-stream: assert rstn low during row 1 with 1 pair buffered -> all valids 0 immediately, state IDLE; a new cfg_start job runs cleanly.
REQ-037 Throughput: all readys high, 64 back-to-back elements -> 64 pairs in 64 consecutive cycles after 2-cycle latency.
